// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one byte in, one framed serial word out.
// Frame = start(0), 8 data bits LSB first, optional parity, STOP_BITS stop(1).
// All outputs are registered; uart_txd idles high.
module uart_tx_serializer #(
  parameter int CLOCKS_PER_BIT = 868,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic       clock,
  input  logic       srst,
  input  logic [7:0] uart_tx_value,
  input  logic       uart_tx_value_write,
  output logic       uart_tx_value_done,
  output logic       uart_tx_busy,
  output logic       uart_txd
);

  localparam int            CW        = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLOCKS_PER_BIT - 1);
  // done is registered, so it is raised one cycle before the final cycle
  localparam logic [CW-1:0] CNT_PRE   = CW'(CLOCKS_PER_BIT - 2);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  // Reject illegal parameterisations at elaboration
  generate
    if (CLOCKS_PER_BIT < 2 || CLOCKS_PER_BIT > 65535) begin : g_bad_cpb
      $error("%m: CLOCKS_PER_BIT=%0d outside legal range 2..65535", CLOCKS_PER_BIT);
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
      $error("%m: PARITY=%0d must be 0 (none), 1 (even) or 2 (odd)", PARITY);
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("%m: STOP_BITS=%0d must be 1 or 2", STOP_BITS);
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic          stop_q;
  logic [7:0]    sh_q;
  logic          par_q;
  logic          txd_q;
  logic          busy_q;
  logic          done_q;

  logic          par_d;
  logic          bit_end_d;

  // Parity of the incoming byte and end-of-bit-period detect
  always_comb begin
    par_d     = (PARITY == 2) ? ~(^uart_tx_value) : (^uart_tx_value);
    bit_end_d = (cnt_q == CNT_LAST);
  end

  // Frame sequencer; busy is low exactly in IDLE, so IDLE alone gates acceptance
  always_ff @(posedge clock) begin
    if (srst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != ST_IDLE) begin
        cnt_q <= bit_end_d ? '0 : cnt_q + 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (uart_tx_value_write) begin
            state_q <= ST_START;
            sh_q    <= uart_tx_value;
            par_q   <= par_d;
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        ST_START: begin
          if (bit_end_d) begin
            state_q <= ST_DATA;
            bit_q   <= '0;
            txd_q   <= sh_q[0];
            sh_q    <= {1'b0, sh_q[7:1]};
          end
        end
        ST_DATA: begin
          if (bit_end_d) begin
            if (bit_q == 3'd7) begin
              if (PARITY != 0) begin
                state_q <= ST_PARITY;
                txd_q   <= par_q;
              end else begin
                state_q <= ST_STOP;
                stop_q  <= 1'b0;
                txd_q   <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + 3'd1;
              txd_q <= sh_q[0];
              sh_q  <= {1'b0, sh_q[7:1]};
            end
          end
        end
        ST_PARITY: begin
          if (bit_end_d) begin
            state_q <= ST_STOP;
            stop_q  <= 1'b0;
            txd_q   <= 1'b1;
          end
        end
        ST_STOP: begin
          if (stop_q == STOP_LAST && cnt_q == CNT_PRE) begin
            done_q <= 1'b1;
          end
          if (bit_end_d) begin
            if (stop_q == STOP_LAST) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              stop_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign uart_txd           = txd_q;
  assign uart_tx_busy       = busy_q;
  assign uart_tx_value_done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer. Lanes 0..2 run at 4 clocks/bit with
// parity none/even/odd and 1/1/2 stop bits and are checked cycle by cycle
// against a timeline scoreboard; lane 3 runs at 868 clocks/bit and is
// checked by a UART receiver model.
module tb_uart_tx_serializer;

  localparam int C3 = 868;

  logic       clock;
  logic       srst;
  logic [3:0] wr;
  logic [7:0] val [4];
  logic [3:0] txd_w, busy_w, done_w;

  int npass = 0, nchk = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int t0 = 0;
  int rx_n = 0;
  int d3_done = 0;

  typedef struct packed {
    logic [2:0] txd;
    logic [2:0] busy;
    logic [2:0] done;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] byteq[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  uart_tx_serializer #(.CLOCKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_d0 (
    .clock(clock), .srst(srst), .uart_tx_value(val[0]), .uart_tx_value_write(wr[0]),
    .uart_tx_value_done(done_w[0]), .uart_tx_busy(busy_w[0]), .uart_txd(txd_w[0]));
  uart_tx_serializer #(.CLOCKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u_d1 (
    .clock(clock), .srst(srst), .uart_tx_value(val[1]), .uart_tx_value_write(wr[1]),
    .uart_tx_value_done(done_w[1]), .uart_tx_busy(busy_w[1]), .uart_txd(txd_w[1]));
  uart_tx_serializer #(.CLOCKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2)) u_d2 (
    .clock(clock), .srst(srst), .uart_tx_value(val[2]), .uart_tx_value_write(wr[2]),
    .uart_tx_value_done(done_w[2]), .uart_tx_busy(busy_w[2]), .uart_txd(txd_w[2]));
  uart_tx_serializer #(.CLOCKS_PER_BIT(C3), .PARITY(0), .STOP_BITS(1)) u_d3 (
    .clock(clock), .srst(srst), .uart_tx_value(val[3]), .uart_tx_value_write(wr[3]),
    .uart_tx_value_done(done_w[3]), .uart_tx_busy(busy_w[3]), .uart_txd(txd_w[3]));

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Expected line waveform for one frame on lanes 0..2 (4 clocks/bit),
  // preceded by the idle acceptance cycle; ncut>=0 truncates the frame.
  task automatic push_frame(int lane, logic [7:0] v, int ncut);
    logic bits[$];
    exp_t e;
    int   n;
    int   idx;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(v[i]);
    if (lane == 1) bits.push_back(^v);
    if (lane == 2) bits.push_back(~(^v));
    bits.push_back(1'b1);
    if (lane == 2) bits.push_back(1'b1);
    e = '{txd: 3'b111, busy: 3'b000, done: 3'b000};
    sbq.push_back(e);
    n = bits.size() * 4;
    for (int k = 0; k < bits.size(); k++) begin
      for (int c = 0; c < 4; c++) begin
        idx = k * 4 + c;
        if (ncut < 0 || idx < ncut) begin
          e = '{txd: 3'b111, busy: 3'b000, done: 3'b000};
          e.txd[lane]  = bits[k];
          e.busy[lane] = 1'b1;
          e.done[lane] = (idx == n - 1);
          sbq.push_back(e);
        end
      end
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Present a one-cycle write; acc says whether the bench expects acceptance
  task automatic write(int lane, logic [7:0] v, bit acc, int ncut = -1);
    val[lane] = v;
    wr[lane]  = 1'b1;
    if (acc) begin
      if (lane == 3) byteq.push_back(v);
      else push_frame(lane, v, ncut);
    end
    @(posedge clock);
    #1;
    wr[lane]  = 1'b0;
    val[lane] = 8'($urandom);
  endtask

  // Cycle-accurate monitor for lanes 0..2; empty timeline means idle
  always @(negedge clock) begin
    exp_t e;
    if (mon_en) begin
      if (sbq.size() != 0) e = sbq.pop_front();
      else e = '{txd: 3'b111, busy: 3'b000, done: 3'b000};
      check("txd", {29'd0, txd_w[2:0]}, {29'd0, e.txd});
      check("busy", {29'd0, busy_w[2:0]}, {29'd0, e.busy});
      check("done", {29'd0, done_w[2:0]}, {29'd0, e.done});
    end
  end

  // Receiver model for lane 3: mid-bit sampling from the start-bit edge
  initial begin : rx_model
    logic [7:0] b;
    logic [8:0] expb;
    forever begin
      @(negedge clock);
      if (mon_en && srst == 1'b0 && txd_w[3] === 1'b0) begin
        t0 = cyc;
        repeat (C3 / 2) @(negedge clock);
        check("rx start bit", {31'd0, txd_w[3]}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (C3) @(negedge clock);
          b[i] = txd_w[3];
        end
        repeat (C3) @(negedge clock);
        check("rx stop bit", {31'd0, txd_w[3]}, 32'd1);
        expb = (byteq.size() != 0) ? {1'b1, byteq.pop_front()} : 9'h000;
        check("rx byte", {23'd0, 1'b1, b}, {23'd0, expb});
        rx_n++;
      end
    end
  end

  // Bit period measured from start-bit edge to done: 10 bits in NB*C-1 cycles
  always @(negedge clock) begin
    if (mon_en && done_w[3] === 1'b1) begin
      d3_done++;
      check("bit period", (cyc - t0 + 1) / 10, C3);
    end
  end

  initial begin : stim
    srst = 1'b1;
    wr   = '0;
    for (int i = 0; i < 4; i++) val[i] = 8'h00;
    idle(2);
    mon_en = 1'b1;

    // write during reset is ignored
    write(0, 8'h3C, 1'b0);
    idle(1);
    srst = 1'b0;
    idle(2);

    // 0xA5 frame with an ignored write at T+5
    write(0, 8'hA5, 1'b1);
    idle(4);
    write(0, 8'h5A, 1'b0);
    idle(37);

    // 0x00 then 0xFF back to back; write in the done cycle is ignored
    write(0, 8'h00, 1'b1);
    idle(39);
    write(0, 8'hC3, 1'b0);
    write(0, 8'hFF, 1'b1);
    idle(44);

    // parity even / odd, two stop bits
    write(1, 8'h07, 1'b1);
    idle(44);
    write(2, 8'h07, 1'b1);
    idle(52);
    write(1, 8'h80, 1'b1);
    idle(44);

    // reset mid-frame at T+15, clean frame at T+20
    write(0, 8'h96, 1'b1, 15);
    idle(14);
    srst = 1'b1;
    idle(1);
    srst = 1'b0;
    idle(4);
    write(0, 8'h3B, 1'b1);
    idle(44);
    check("scoreboard drained", sbq.size(), 0);

    // random bytes at full baud divisor, back to back
    for (int n = 0; n < 3; n++) begin
      write(3, 8'($urandom), 1'b1);
      idle(10 * C3);
    end
    for (int k = 0; k < 20000 && rx_n < 3; k++) @(posedge clock);
    idle(2);
    check("rx frame count", rx_n, 3);
    check("lane3 done count", d3_done, 3);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
